// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock behind a start/done handshake.
// Optional macro DIVIDER_DIV_ZERO_FAST_EN: a zero divisor bypasses CALC and reports in one cycle.
module divider_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvs_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] remd_r;
    logic             dz_r;

    logic             accept_s;
    logic             zero_s;
    logic             last_s;
    logic [WIDTH:0]   r_shift_s;
    logic             ge_s;
    logic [WIDTH-1:0] r_next_s;
    logic [WIDTH-1:0] q_next_s;

    assign accept_s = start && (state_r != ST_CALC);
    assign zero_s   = (divisor == {WIDTH{1'b0}});
    assign last_s   = (state_r == ST_CALC) && (cnt_r == LAST_ITER);

    // One shift-and-subtract step; the final remainder always fits in WIDTH bits.
    always_comb begin
        r_shift_s = {rem_r, q_r[WIDTH-1]};
        ge_s      = (r_shift_s >= {1'b0, dvs_r});
        if (ge_s) begin
            r_next_s = r_shift_s[WIDTH-1:0] - dvs_r;
        end else begin
            r_next_s = r_shift_s[WIDTH-1:0];
        end
        q_next_s = {q_r[WIDTH-2:0], ge_s};
    end

    // Next-state decode for the IDLE/CALC/DONE controller.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
`ifdef DIVIDER_DIV_ZERO_FAST_EN
                    if (zero_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CALC;
                    end
`else
                    state_s = ST_CALC;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Controller state and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_CALC);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Working registers: the quotient register starts as the dividend and shifts it out MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            rem_r <= {WIDTH{1'b0}};
            q_r   <= {WIDTH{1'b0}};
            dvs_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CW{1'b0}};
            rem_r <= {WIDTH{1'b0}};
            q_r   <= dividend;
            dvs_r <= divisor;
        end else if ((state_r == ST_CALC) && !last_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            rem_r <= r_next_s;
            q_r   <= q_next_s;
        end else begin
            cnt_r <= cnt_r;
            rem_r <= rem_r;
            q_r   <= q_r;
            dvs_r <= dvs_r;
        end
    end

    // Result registers update only on entry to DONE and otherwise hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_r <= {WIDTH{1'b0}};
            remd_r <= {WIDTH{1'b0}};
            dz_r   <= 1'b0;
        end else if (last_s) begin
            quot_r <= q_r;
            remd_r <= rem_r;
            dz_r   <= (dvs_r == {WIDTH{1'b0}});
`ifdef DIVIDER_DIV_ZERO_FAST_EN
        end else if (accept_s && zero_s) begin
            quot_r <= {WIDTH{1'b1}};
            remd_r <= dividend;
            dz_r   <= 1'b1;
`endif
        end else begin
            quot_r <= quot_r;
            remd_r <= remd_r;
            dz_r   <= dz_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quot_r;
    assign remainder = remd_r;
    assign div_zero  = dz_r;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq (WIDTH=4): the driver pushes hand-computed results,
// a negedge monitor pops and checks them, including done latency in cycles.
module tb_divider_seq;

    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] dividend = 4'd0;
    logic [W-1:0] divisor  = 4'd0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    divider_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

`ifdef DIVIDER_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller sits just after a negedge; start is accepted on the following posedge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.cyc = (FAST && (b == 4'd0)) ? cyc : cyc + W + 1;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got pending=%0d expected pending=0", name, sb.size());
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got q=%0d r=%0d expected no done", quotient, remainder);
            end else begin
                mon_e = sb.pop_front();
                check("quotient",  32'(quotient),  32'(mon_e.q));
                check("remainder", 32'(remainder), 32'(mon_e.r));
                check("div_zero",  32'(div_zero),  32'(mon_e.dz));
                check("latency",   32'(cyc),       32'(mon_e.cyc));
                check("busy_at_done", 32'(busy),   32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q",    32'(quotient), 32'd0);
        check("rst_r",    32'(remainder), 32'd0);
        check("rst_dz",   32'(div_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal division
        @(negedge clk);
        do_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_idle("t1");

        // Edge operands
        do_op(4'd15, 4'd1,  4'd15, 4'd0, 1'b0); wait_idle("t2a");
        do_op(4'd7,  4'd9,  4'd0,  4'd7, 1'b0); wait_idle("t2b");
        do_op(4'd0,  4'd5,  4'd0,  4'd0, 1'b0); wait_idle("t2c");
        do_op(4'd15, 4'd15, 4'd1,  4'd0, 1'b0); wait_idle("t2d");

        // Divide by zero
        do_op(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
        check("busy_div0", 32'(busy), FAST ? 32'd0 : 32'd1);
        wait_idle("t3");

        // Start ignored while busy
        do_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        @(negedge clk);
        dividend = 4'd8;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t4");

        // Back-to-back: new start in the DONE cycle
        do_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("b2b_first_done_seen", 32'(seen), 32'd1);
        end
        do_op(4'd14, 4'd4, 4'd3, 4'd2, 1'b0);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_drop", 32'(done), 32'd0);
        wait_idle("t5");

        // Reset on the second CALC cycle
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q",    32'(quotient), 32'd0);
        check("midrst_r",    32'(remainder), 32'd0);
        check("midrst_dz",   32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(4'd6, 4'd2, 4'd3, 4'd0, 1'b0);
        wait_idle("t6");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
